uart_rx_mmio: RTL

- Memory-mapped UART receiver. Deserializes 8N1 frames arriving on the board RX pin into a small FIFO.
- The CPU reads received bytes and status with LW through the memory manager's UART region. This is the receive-side counterpart of the existing TX path.
- Sits beside the UART transmitter under the memory manager. It is selected by the same uart_en/uart_we strobes.

---
 rtl/uart_rx_mmio.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: 16x oversampled deserializer feeding a small
// receive FIFO, with DATA (pop-on-read) and STATUS (W1C flags) registers.
module uart_rx_mmio #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic        uart_en,
    input  logic        uart_we,
    input  logic [2:0]  addr,
    input  logic [31:0] uart_wdata,
    output logic [31:0] uart_rdata,
    output logic        rx_irq
);

    localparam int unsigned DIV   = CLK_FREQ / (BAUD * 16);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic             r_sync1, r_sync2;
    logic             w_rx_s;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    state_t           r_state, w_state_nxt;
    logic [3:0]       r_scnt, w_scnt_nxt;
    logic [2:0]       r_bcnt, w_bcnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             w_push, w_ferr_set, w_div_clr;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overrun, r_frame_err;
    logic             w_empty, w_full, w_pop, w_push_ok, w_clr_wr;
    logic             w_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= uart_rx;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx_s = r_sync2;

    // Divider restarts on an accepted start edge so ticks are phase-aligned to it.
    assign w_tick = (r_div == DIV_W'(DIV - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  r_div <= '0;
        else if (w_div_clr || w_tick) r_div <= '0;
        else                      r_div <= r_div + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_scnt  <= '0;
            r_bcnt  <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        w_bcnt_nxt  = r_bcnt;
        w_shift_nxt = r_shift;
        w_push      = 1'b0;
        w_ferr_set  = 1'b0;
        w_div_clr   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = S_START;
                    w_scnt_nxt  = '0;
                    w_div_clr   = 1'b1;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_scnt == 4'd7) begin
                        w_scnt_nxt  = '0;
                        w_bcnt_nxt  = '0;
                        w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        w_scnt_nxt = r_scnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_scnt == 4'd15) begin
                        w_scnt_nxt  = '0;
                        w_shift_nxt = {w_rx_s, r_shift[7:1]};
                        if (r_bcnt == 3'd7) w_state_nxt = S_STOP;
                        else                w_bcnt_nxt  = r_bcnt + 1'b1;
                    end else begin
                        w_scnt_nxt = r_scnt + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_scnt == 4'd15) begin
                        w_scnt_nxt  = '0;
                        w_state_nxt = S_IDLE;
                        w_push      = w_rx_s;
                        w_ferr_set  = ~w_rx_s;
                    end else begin
                        w_scnt_nxt = r_scnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop     = uart_en && !uart_we && (addr == 3'h0) && !w_empty;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO is still taken.
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_clr_wr  = uart_en && uart_we && (addr == 3'h4);

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop)      r_overrun <= 1'b1;
            else if (w_clr_wr && uart_wdata[2])  r_overrun <= 1'b0;
            if (w_ferr_set)                      r_frame_err <= 1'b1;
            else if (w_clr_wr && uart_wdata[3])  r_frame_err <= 1'b0;
        end
    end

    always_comb begin
        uart_rdata = '0;
        if (uart_en) begin
            case (addr)
                3'h0:    if (!w_empty) uart_rdata = {24'b0, r_mem[r_rptr]};
                3'h4:    uart_rdata = {28'b0, r_frame_err, r_overrun, w_full, ~w_empty};
                default: uart_rdata = '0;
            endcase
        end
    end

    assign rx_irq   = ~w_empty;
    assign w_unused = ^{uart_wdata[31:4], uart_wdata[1:0]};

endmodule
